audio_stream_arbiter: RTL and testbench
=======================================

# audio_stream_arbiter

Round-robin packet arbiter that shares the single-bit audio mixer sink stream among N_CH serial audio source streams. A whole packet (start_packet to end_packet) is granted atomically, so channels are never interleaved mid-packet. Sits directly upstream of the mixer's d_* sink. Enable mask, status, counters and (optionally) a stall watchdog are exposed on a 3-bit CSR port.

## Interface
- N_CH, 4: number of requesting source streams, 2..8.
- iCLOCK  in  1  single clock for streams and CSR.
- iRESET_n  in  1  reset, asynchronous, active-low.
- r_data_valid  in  N_CH  per-channel beat valid.
- r_ready  out  N_CH  per-channel beat accept.
- r_start_packet  in  N_CH  per-channel first beat of packet.
- r_end_packet  in  N_CH  per-channel last beat of packet.
- r_data  in  N_CH  per-channel serial data bit.
- m_data_valid  out  1  to mixer d_data_valid.
- m_ready  in  1  from mixer d_ready.
- m_start_packet, m_end_packet, m_data  out  1 each  to mixer.
- iCSR_ADDRESS  in  3  register select.
- iCSR_READ  in  1  read strobe.
- oCSR_READ_DATA  out  32  registered read data.
- iCSR_WRITE  in  1  write strobe.
- iCSR_WRITE_DATA  in  32  write data.

## Operation
- A beat transfers on a port when valid && ready are both high in the same cycle.
- FSM has two states: IDLE and XFER.
- IDLE
  - Candidates are channels with r_data_valid && r_start_packet && enabled (CTRL.en && mask bit).
  - The lowest index greater than last_grant wins, wrapping around. grant and last_grant are registered. Go to XFER.
  - All m_* outputs are 0.
  - An enabled channel with valid && !start_packet is drained: r_ready=1, the beat is discarded and DROP_COUNT increments.
  - Disabled channels are held at r_ready=0.
- XFER
  - Combinational passthrough of the granted channel: m_* = r_*[grant], r_ready[grant] = m_ready. All other r_ready are 0 (orphan drain excepted).
  - When the end_packet beat transfers: PKT_COUNT increments, go to IDLE.
- Enable changes (mask or CTRL.en) mid-packet do not truncate the packet; they take effect at the next IDLE.
- CSR map (unmapped addresses read 0, writes ignored):
  - 0 CTRL, RW: bit0 en, [15:8] mask.
  - 1 STATUS, RO: bit0 busy (XFER), bit1 timeout sticky (write 1 to clear via addr 1), [6:4] grant, [15:8] pending candidates, [23:16] orphan flags.
  - 2 PKT_COUNT, RW-clear.
  - 3 DROP_COUNT, RW-clear.
  - 5 TIMEOUT, RW, 16-bit.
- Counters are 32-bit and saturate at 0xFFFFFFFF. Any write clears them. Clear wins over a same-cycle increment.

## Timing
- Reset values: all outputs 0 (r_ready, m_*, oCSR_READ_DATA). grant=0, last_grant=N_CH-1, CTRL=0, counters 0, TIMEOUT=0, orphan flags 0.
- Arbitration takes 1 cycle. A request seen in cycle t is forwarded from cycle t+1, so each packet costs exactly one bubble cycle.
- Passthrough in XFER has zero latency.
- oCSR_READ_DATA is valid the cycle after iCSR_READ.
- A CSR write takes effect the cycle after iCSR_WRITE. Read and write in the same cycle return the old value.
- A single-beat packet (start and end on the same beat) completes XFER in 1 cycle.
- Reset mid-packet aborts immediately. Nothing is flushed.

## Configuration
- AUDIO_ARB_TIMEOUT_EN defined: the watchdog is compiled in.
  - Trigger: in XFER, TIMEOUT != 0, and no beat transfers for TIMEOUT consecutive cycles (counting either stall side).
  - Response: the arbiter sets STATUS.timeout, sets the orphan flag of the granted channel and returns to IDLE. The mixer sees a truncated packet.
  - An orphaned channel has r_ready=1 regardless of enable and the FSM. Its beats are discarded and counted in DROP_COUNT. The flag clears on its end_packet beat, and the channel is not a candidate while orphaned.
- AUDIO_ARB_TIMEOUT_EN undefined: there is no watchdog. Address 5 reads 0. STATUS bits 1 and [23:16] read 0.

## Test plan
- Round-robin: CTRL=0x0F01, channels 0..3 each hold a ready 3-beat packet, m_ready=1 -> grant order 0,1,2,3,0. PKT_COUNT=5 after five packets. Exactly 1 bubble cycle between packets.
- Mask: mask=0x05, all channels request -> only channels 0 and 2 alternate. r_ready[1] and r_ready[3] stay 0.
- Mid-packet garbage: channel 1 presents 4 beats with valid=1 and start_packet=0 while the FSM is IDLE -> all 4 beats accepted and discarded, DROP_COUNT=4, no m_data_valid.
- Backpressure: m_ready toggles 1,0,1,0 during an 8-beat packet -> output data matches input bit-for-bit, and grant is held until the end beat transfers.
- Timeout (macro on): TIMEOUT=10, channel 2 stalls valid=0 after 2 beats -> return to IDLE on the 10th idle cycle, STATUS.timeout=1, orphan bit 2 set. The remaining beats of channel 2 are dropped up to and including end_packet, after which orphan bit 2 clears.
- Async reset asserted mid-XFER -> all outputs 0 in the same cycle, and every CSR reads its reset value after release.

Source files
------------

// File: rtl/audio_stream_arbiter.sv
// Round-robin packet arbiter: N_CH serial audio streams share one mixer sink, whole packets at a time.
// Optional stall watchdog with orphan draining is compiled in when AUDIO_ARB_TIMEOUT_EN is defined.
module audio_stream_arbiter #(
    parameter int N_CH = 4
) (
    input  logic            iCLOCK,
    input  logic            iRESET_n,
    input  logic [N_CH-1:0] r_data_valid,
    output logic [N_CH-1:0] r_ready,
    input  logic [N_CH-1:0] r_start_packet,
    input  logic [N_CH-1:0] r_end_packet,
    input  logic [N_CH-1:0] r_data,
    output logic            m_data_valid,
    input  logic            m_ready,
    output logic            m_start_packet,
    output logic            m_end_packet,
    output logic            m_data,
    input  logic [2:0]      iCSR_ADDRESS,
    input  logic            iCSR_READ,
    output logic [31:0]     oCSR_READ_DATA,
    input  logic            iCSR_WRITE,
    input  logic [31:0]     iCSR_WRITE_DATA
);

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_PKT     = 3'd2;
    localparam logic [2:0] ADDR_DROP    = 3'd3;
    localparam logic [2:0] ADDR_TIMEOUT = 3'd5;

    typedef enum logic {ST_IDLE, ST_XFER} state_t;

    state_t      r_state;
    logic [2:0]  r_grant;
    logic [2:0]  r_last_grant;
    logic        r_en;
    logic [7:0]  r_mask;
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_drop_cnt;

    logic [7:0]  w_valid, w_start, w_end, w_data;
    logic [7:0]  w_cand, w_drain, w_ready, w_drop, w_orphan;
    logic [2:0]  w_pick, w_idx;
    logic        w_pick_any;
    logic        w_busy, w_beat, w_end_beat;
    logic        w_timeout_fire, w_to_flag;
    logic [31:0] w_timeout_val;
    logic [3:0]  w_drop_num;
    logic [31:0] w_rdata;
    logic        w_wr_ctrl, w_wr_status, w_wr_pkt, w_wr_drop, w_wr_timeout;
    logic        w_unused_wdata;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [3:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    assign w_busy = (r_state == ST_XFER);

    // Per-channel vectors are padded to 8 lanes so a 3-bit grant can index them directly.
    for (genvar g = 0; g < 8; g++) begin : g_ch
        if (g < N_CH) begin : g_on
            assign w_valid[g] = r_data_valid[g];
            assign w_start[g] = r_start_packet[g];
            assign w_end[g]   = r_end_packet[g];
            assign w_data[g]  = r_data[g];
        end else begin : g_off
            assign w_valid[g] = 1'b0;
            assign w_start[g] = 1'b0;
            assign w_end[g]   = 1'b0;
            assign w_data[g]  = 1'b0;
        end
        assign w_cand[g]  = w_valid[g] & w_start[g] & r_en & r_mask[g] & ~w_orphan[g];
        assign w_drain[g] = ~w_busy & r_en & r_mask[g] & w_valid[g] & ~w_start[g];
        assign w_ready[g] = w_orphan[g] | w_drain[g] | (w_busy & (r_grant == 3'(g)) & m_ready);
        assign w_drop[g]  = w_valid[g] & (w_orphan[g] | w_drain[g]);
    end

    assign r_ready        = w_ready[N_CH-1:0];
    assign m_data_valid   = w_busy & w_valid[r_grant];
    assign m_start_packet = w_busy & w_start[r_grant];
    assign m_end_packet   = w_busy & w_end[r_grant];
    assign m_data         = w_busy & w_data[r_grant];
    assign w_beat         = m_data_valid & m_ready;
    assign w_end_beat     = w_beat & m_end_packet;
    assign w_drop_num     = 4'($countones(w_drop));

    // Scan from the largest offset down so the nearest channel after last_grant wins.
    always_comb begin
        w_pick     = '0;
        w_pick_any = 1'b0;
        w_idx      = '0;
        for (int off = N_CH; off >= 1; off--) begin
            w_idx = 3'((int'(r_last_grant) + off) % N_CH);
            if (w_cand[w_idx]) begin
                w_pick     = w_idx;
                w_pick_any = 1'b1;
            end
        end
    end

    assign w_wr_ctrl      = iCSR_WRITE && (iCSR_ADDRESS == ADDR_CTRL);
    assign w_wr_status    = iCSR_WRITE && (iCSR_ADDRESS == ADDR_STATUS);
    assign w_wr_pkt       = iCSR_WRITE && (iCSR_ADDRESS == ADDR_PKT);
    assign w_wr_drop      = iCSR_WRITE && (iCSR_ADDRESS == ADDR_DROP);
    assign w_wr_timeout   = iCSR_WRITE && (iCSR_ADDRESS == ADDR_TIMEOUT);
    assign w_unused_wdata = ^{iCSR_WRITE_DATA, w_wr_status, w_wr_timeout};

`ifdef AUDIO_ARB_TIMEOUT_EN
    logic [15:0] r_timeout;
    logic [15:0] r_stall;
    logic [7:0]  r_orphan;
    logic        r_to_flag;
    logic [7:0]  w_orph_set, w_orph_clr;

    assign w_orphan       = r_orphan;
    assign w_to_flag      = r_to_flag;
    assign w_timeout_val  = {16'd0, r_timeout};
    assign w_timeout_fire = w_busy && !w_beat && (r_timeout != 16'd0) &&
                            (({1'b0, r_stall} + 17'd1) == {1'b0, r_timeout});
    assign w_orph_set     = w_timeout_fire ? (8'd1 << r_grant) : 8'd0;
    assign w_orph_clr     = r_orphan & w_valid & w_end;

    always_ff @(posedge iCLOCK or negedge iRESET_n) begin
        if (!iRESET_n) begin
            r_timeout <= '0;
            r_stall   <= '0;
            r_orphan  <= '0;
            r_to_flag <= 1'b0;
        end else begin
            if (!w_busy || w_beat)
                r_stall <= '0;
            else if (r_stall != 16'hFFFF)
                r_stall <= r_stall + 16'd1;
            r_orphan <= (r_orphan & ~w_orph_clr) | w_orph_set;
            if (w_timeout_fire)
                r_to_flag <= 1'b1;
            else if (w_wr_status && iCSR_WRITE_DATA[1])
                r_to_flag <= 1'b0;
            if (w_wr_timeout)
                r_timeout <= iCSR_WRITE_DATA[15:0];
        end
    end
`else
    assign w_orphan       = '0;
    assign w_to_flag      = 1'b0;
    assign w_timeout_val  = '0;
    assign w_timeout_fire = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (iCSR_ADDRESS)
            ADDR_CTRL:    w_rdata = {16'd0, r_mask, 7'd0, r_en};
            ADDR_STATUS:  w_rdata = {8'd0, w_orphan, w_cand, 1'b0, r_grant, 2'd0, w_to_flag, w_busy};
            ADDR_PKT:     w_rdata = r_pkt_cnt;
            ADDR_DROP:    w_rdata = r_drop_cnt;
            ADDR_TIMEOUT: w_rdata = w_timeout_val;
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge iRESET_n) begin
        if (!iRESET_n) begin
            r_state        <= ST_IDLE;
            r_grant        <= '0;
            r_last_grant   <= 3'(N_CH - 1);
            r_en           <= 1'b0;
            r_mask         <= '0;
            r_pkt_cnt      <= '0;
            r_drop_cnt     <= '0;
            oCSR_READ_DATA <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_state      <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_end_beat || w_timeout_fire)
                        r_state <= ST_IDLE;
                end
            endcase

            if (w_wr_ctrl) begin
                r_en   <= iCSR_WRITE_DATA[0];
                r_mask <= iCSR_WRITE_DATA[15:8];
            end

            if (w_wr_pkt)
                r_pkt_cnt <= '0;
            else if (w_end_beat)
                r_pkt_cnt <= sat_add(r_pkt_cnt, 4'd1);

            if (w_wr_drop)
                r_drop_cnt <= '0;
            else if (w_drop_num != 4'd0)
                r_drop_cnt <= sat_add(r_drop_cnt, w_drop_num);

            if (iCSR_READ)
                oCSR_READ_DATA <= w_rdata;
        end
    end

endmodule

// File: tb/tb_audio_stream_arbiter.sv
// Directed bench for audio_stream_arbiter: per-channel source queues feed the DUT, a scoreboard checks mixer beats.
// Timeout/orphan checks are active when AUDIO_ARB_TIMEOUT_EN is defined.
module tb_audio_stream_arbiter;

    localparam int N_CH = 4;

    typedef struct packed { logic v; logic s; logic e; logic d; } beat_t;
    typedef struct packed { logic [2:0] ch; logic s; logic e; logic d; } exp_t;

    logic            iCLOCK = 1'b0;
    logic            iRESET_n;
    logic [N_CH-1:0] r_data_valid, r_ready, r_start_packet, r_end_packet, r_data;
    logic            m_data_valid, m_ready, m_start_packet, m_end_packet, m_data;
    logic [2:0]      iCSR_ADDRESS;
    logic            iCSR_READ, iCSR_WRITE;
    logic [31:0]     oCSR_READ_DATA, iCSR_WRITE_DATA;

    audio_stream_arbiter #(.N_CH(N_CH)) dut (
        .iCLOCK(iCLOCK), .iRESET_n(iRESET_n),
        .r_data_valid(r_data_valid), .r_ready(r_ready),
        .r_start_packet(r_start_packet), .r_end_packet(r_end_packet), .r_data(r_data),
        .m_data_valid(m_data_valid), .m_ready(m_ready),
        .m_start_packet(m_start_packet), .m_end_packet(m_end_packet), .m_data(m_data),
        .iCSR_ADDRESS(iCSR_ADDRESS), .iCSR_READ(iCSR_READ), .oCSR_READ_DATA(oCSR_READ_DATA),
        .iCSR_WRITE(iCSR_WRITE), .iCSR_WRITE_DATA(iCSR_WRITE_DATA)
    );

    always #5 iCLOCK = ~iCLOCK;

    beat_t     src_q [N_CH][$];
    exp_t      exp_q [$];
    int        n_pass = 0;
    int        n_chk  = 0;
    int        cyc    = 0;
    int        prev_end = 0;
    bit        have_prev = 0, chk_bubble = 0, mask_mode = 0, mask_viol = 0, garb_mode = 0, bp_mode = 0;
    logic [N_CH-1:0] acc;
    logic [31:0] d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic present();
        for (int c = 0; c < N_CH; c++) begin
            if (src_q[c].size() != 0) begin
                r_data_valid[c]   = src_q[c][0].v;
                r_start_packet[c] = src_q[c][0].s;
                r_end_packet[c]   = src_q[c][0].e;
                r_data[c]         = src_q[c][0].d;
            end else begin
                r_data_valid[c] = 1'b0; r_start_packet[c] = 1'b0;
                r_end_packet[c] = 1'b0; r_data[c] = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   ch;
        acc = r_data_valid & r_ready;
        if (mask_mode && (r_ready[1] || r_ready[3])) mask_viol = 1'b1;
        if (garb_mode) check("garbage_no_m_valid", 32'(m_data_valid), 32'd0);
        if (m_data_valid && m_ready) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ch = 7;
                for (int c = N_CH - 1; c >= 0; c--) if (acc[c]) ch = c;
                check("beat_ch_s_e_d", 32'({3'(ch), m_start_packet, m_end_packet, m_data}), 32'(e));
                if (chk_bubble && m_start_packet && have_prev)
                    check("bubble_gap", 32'(cyc - prev_end), 32'd2);
                if (m_end_packet) begin prev_end = cyc; have_prev = 1'b1; end
            end
        end
    endtask

    task automatic tick();
        if (bp_mode) m_ready = ~m_ready;
        present();
        @(negedge iCLOCK);
        monitor();
        @(posedge iCLOCK);
        #1;
        for (int c = 0; c < N_CH; c++)
            if (src_q[c].size() != 0 && (!src_q[c][0].v || acc[c])) void'(src_q[c].pop_front());
        cyc++;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] rd);
        iCSR_ADDRESS = a; iCSR_READ = 1'b1;
        tick();
        iCSR_READ = 1'b0;
        rd = oCSR_READ_DATA;
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] wd);
        iCSR_ADDRESS = a; iCSR_WRITE = 1'b1; iCSR_WRITE_DATA = wd;
        tick();
        iCSR_WRITE = 1'b0;
    endtask

    task automatic push_pkt(input int ch, input int n, input logic [15:0] bits, input bit expect_out);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b = '{v: 1'b1, s: (i == 0), e: (i == n - 1), d: bits[i]};
            src_q[ch].push_back(b);
            if (expect_out) exp_q.push_back(exp_t'({3'(ch), b.s, b.e, b.d}));
        end
    endtask

    task automatic push_raw(input int ch, input logic s, input logic e, input logic dd, input bit expect_out);
        beat_t b;
        b = '{v: 1'b1, s: s, e: e, d: dd};
        src_q[ch].push_back(b);
        if (expect_out) exp_q.push_back(exp_t'({3'(ch), s, e, dd}));
    endtask

    task automatic wait_exp_empty(input string tag, input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin tick(); n++; end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_src_empty(input string tag, input int ch, input int max);
        int n = 0;
        while (src_q[ch].size() != 0 && n < max) begin tick(); n++; end
        check(tag, 32'(src_q[ch].size()), 32'd0);
    endtask

    initial begin
        iRESET_n = 1'b0; m_ready = 1'b1;
        r_data_valid = '0; r_start_packet = '0; r_end_packet = '0; r_data = '0;
        iCSR_ADDRESS = '0; iCSR_READ = 1'b0; iCSR_WRITE = 1'b0; iCSR_WRITE_DATA = '0;
        repeat (2) @(posedge iCLOCK);
        #1;
        check("rst_r_ready", 32'(r_ready), 32'd0);
        check("rst_m_out", 32'({m_data_valid, m_start_packet, m_end_packet, m_data}), 32'd0);
        check("rst_csr_rdata", oCSR_READ_DATA, 32'd0);
        iRESET_n = 1'b1;
        csr_read(3'd0, d); check("rst_ctrl", d, 32'd0);
        csr_read(3'd1, d); check("rst_status", d, 32'd0);
        csr_read(3'd2, d); check("rst_pkt", d, 32'd0);
        csr_read(3'd3, d); check("rst_drop", d, 32'd0);
        csr_read(3'd5, d); check("rst_timeout", d, 32'd0);

        // Round-robin over four channels, channel 0 twice.
        csr_write(3'd0, 32'h0F01);
        chk_bubble = 1'b1; have_prev = 1'b0;
        push_pkt(0, 3, 16'b101, 1'b1);
        push_pkt(1, 3, 16'b011, 1'b1);
        push_pkt(2, 3, 16'b110, 1'b1);
        push_pkt(3, 3, 16'b001, 1'b1);
        push_pkt(0, 3, 16'b010, 1'b1);
        wait_exp_empty("rr_done", 60);
        chk_bubble = 1'b0;
        csr_read(3'd2, d); check("rr_pkt_count", d, 32'd5);

        // Counter clear, same-cycle read/write, unmapped addresses.
        csr_write(3'd2, 32'h1);
        csr_read(3'd2, d); check("pkt_clear", d, 32'd0);
        iCSR_ADDRESS = 3'd0; iCSR_READ = 1'b1; iCSR_WRITE = 1'b1; iCSR_WRITE_DATA = 32'h0501;
        tick();
        iCSR_READ = 1'b0; iCSR_WRITE = 1'b0;
        check("rw_same_cycle_old", oCSR_READ_DATA, 32'h0F01);
        csr_read(3'd0, d); check("ctrl_new", d, 32'h0501);
        csr_write(3'd4, 32'hFFFF_FFFF);
        csr_read(3'd4, d); check("unmapped_4", d, 32'd0);
        csr_read(3'd7, d); check("unmapped_7", d, 32'd0);

        // Mask 0x05: only channels 0 and 2 alternate; last grant is 0 so 2 goes first.
        chk_bubble = 1'b1; have_prev = 1'b0; mask_mode = 1'b1; mask_viol = 1'b0;
        push_pkt(2, 3, 16'b100, 1'b1);
        push_pkt(0, 3, 16'b111, 1'b1);
        push_pkt(2, 3, 16'b001, 1'b1);
        push_pkt(0, 3, 16'b000, 1'b1);
        push_pkt(1, 3, 16'b101, 1'b0);
        push_pkt(3, 3, 16'b101, 1'b0);
        wait_exp_empty("mask_done", 60);
        repeat (3) tick();
        check("mask_ready_1_3_low", 32'(mask_viol), 32'd0);
        mask_mode = 1'b0; chk_bubble = 1'b0;
        src_q[1].delete(); src_q[3].delete();
        csr_read(3'd2, d); check("mask_pkt_count", d, 32'd4);

        // Garbage beats on channel 1 while idle are drained and counted.
        csr_write(3'd0, 32'h0F01);
        csr_write(3'd3, 32'h1);
        garb_mode = 1'b1;
        for (int i = 0; i < 4; i++) push_raw(1, 1'b0, 1'b0, 1'(i), 1'b0);
        wait_src_empty("garbage_drained", 1, 20);
        tick();
        garb_mode = 1'b0;
        csr_read(3'd3, d); check("garbage_drop_count", d, 32'd4);

        // Backpressure: m_ready toggles through an 8-beat packet on channel 3.
        bp_mode = 1'b1;
        push_pkt(3, 8, 16'b1011_0010, 1'b1);
        wait_exp_empty("bp_done", 60);
        bp_mode = 1'b0; m_ready = 1'b1;
        tick();
        csr_read(3'd1, d); check("bp_status_idle", d, 32'h30);

`ifdef AUDIO_ARB_TIMEOUT_EN
        // Watchdog: channel 2 stalls after two beats; truncation on the 10th stall cycle.
        csr_write(3'd5, 32'd10);
        csr_read(3'd5, d); check("timeout_reg", d, 32'd10);
        csr_write(3'd3, 32'h1);
        push_raw(2, 1'b1, 1'b0, 1'b1, 1'b1);
        push_raw(2, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (12) tick();
        csr_read(3'd1, d); check("to_still_busy", d, 32'h21);
        csr_read(3'd1, d); check("to_fired_status", d, 32'h0004_0022);
        check("to_truncated_beats", 32'(exp_q.size()), 32'd0);
        garb_mode = 1'b1;
        push_raw(2, 1'b0, 1'b0, 1'b1, 1'b0);
        push_raw(2, 1'b0, 1'b0, 1'b0, 1'b0);
        push_raw(2, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_src_empty("orphan_drained", 2, 20);
        tick();
        garb_mode = 1'b0;
        csr_read(3'd3, d); check("orphan_drop_count", d, 32'd3);
        csr_read(3'd1, d); check("orphan_cleared", d, 32'h22);
        csr_write(3'd1, 32'h2);
        csr_read(3'd1, d); check("timeout_w1c", d, 32'h20);
`else
        csr_write(3'd5, 32'd10);
        csr_read(3'd5, d); check("timeout_absent", d, 32'd0);
`endif

        // Asynchronous reset in the middle of a packet on channel 1.
        push_pkt(1, 6, 16'b10_1101, 1'b1);
        tick(); tick();
        csr_read(3'd0, d); check("pre_reset_ctrl", d, 32'h0F01);
        iRESET_n = 1'b0;
        #1;
        check("arst_m_out", 32'({m_data_valid, m_start_packet, m_end_packet, m_data}), 32'd0);
        check("arst_r_ready", 32'(r_ready), 32'd0);
        check("arst_csr_rdata", oCSR_READ_DATA, 32'd0);
        exp_q.delete();
        src_q[1].delete();
        repeat (2) tick();
        iRESET_n = 1'b1;
        csr_read(3'd0, d); check("post_rst_ctrl", d, 32'd0);
        csr_read(3'd1, d); check("post_rst_status", d, 32'd0);
        csr_read(3'd2, d); check("post_rst_pkt", d, 32'd0);
        csr_read(3'd3, d); check("post_rst_drop", d, 32'd0);
        csr_read(3'd5, d); check("post_rst_timeout", d, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
